// File: rtl/contador_pkg.sv
// contador_pkg
// Shared constants for the contador_ud_param counter family.
//   CONT_WIDTH_DEF : default counter width
//   CONT_MODE_WRAP : SAT parameter value selecting wrap-around at the limits
//   CONT_MODE_SAT  : SAT parameter value selecting saturation at the limits
package contador_pkg;

  localparam int CONT_WIDTH_DEF = 8;

  localparam bit CONT_MODE_WRAP = 1'b0;
  localparam bit CONT_MODE_SAT  = 1'b1;

endpackage

// File: rtl/salida_triestado.sv
// salida_triestado
// Generic WIDTH-bit tri-state bus driver, shared by blocks that drive
// common buses.
// Ports:
//   oe_i   : output enable, 1 = drive bus_o with data_i, 0 = release (Z)
//   data_i : value to present on the bus
//   bus_o  : tri-state bus output
module salida_triestado
  import contador_pkg::*;
#(
  parameter int WIDTH = CONT_WIDTH_DEF
) (
  input  logic             oe_i,
  input  logic [WIDTH-1:0] data_i,
  output tri   [WIDTH-1:0] bus_o
);

  assign bus_o = oe_i ? data_i : {WIDTH{1'bz}};

endmodule

// File: rtl/contador_ud_param.sv
// contador_ud_param
// Parametrised up/down counter with parallel load, programmable upper limit
// MAX (range 0..MAX), wrap or saturate boundary mode, registered one-cycle
// terminal-count pulse and a tri-state copy of the count.
// Optional feature macro: CONT_OVF_FLAG_EN builds the sticky overflow flag;
// without it OVF is tied to 0 and no flag register exists.
// Parameters:
//   WIDTH : counter width (>= 2)
//   SAT   : CONT_MODE_WRAP (0) or CONT_MODE_SAT (1)
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   EN       : count enable
//   LOAD     : parallel load of D, overrides EN
//   UP       : direction, 1 = up, 0 = down
//   OE       : drive enable for Q
//   D        : load value
//   MAX      : upper count limit
//   Q        : tri-state count
//   CNT      : always-driven count
//   TC       : registered boundary-event pulse
//   OVF      : sticky overflow flag (0 unless CONT_OVF_FLAG_EN)
module contador_ud_param
  import contador_pkg::*;
#(
  parameter int WIDTH = CONT_WIDTH_DEF,
  parameter bit SAT   = CONT_MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             LOAD,
  input  logic             UP,
  input  logic             OE,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] MAX,
  output tri   [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] CNT,
  output logic             TC,
  output logic             OVF
);

  localparam bit IS_SAT = (SAT == CONT_MODE_SAT);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             bnd_event;

  // Boundary compares run on the current count before any +/-1, so the
  // increment can never carry out of the register. A count loaded above
  // MAX is caught by the >= compare on the next up edge.
  always_comb begin
    cnt_d     = cnt_q;
    bnd_event = 1'b0;
    if (LOAD) begin
      cnt_d = D;
    end else if (EN) begin
      if (UP) begin
        if (cnt_q >= MAX) begin
          bnd_event = 1'b1;
          cnt_d     = IS_SAT ? MAX : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          bnd_event = 1'b1;
          cnt_d     = IS_SAT ? '0 : MAX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
    tc_d = bnd_event;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

`ifdef CONT_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  // LOAD clears the flag even if the same edge would have set it; a load
  // never produces a boundary event anyway.
  always_comb begin
    ovf_d = ovf_q;
    if (LOAD) begin
      ovf_d = 1'b0;
    end else if (bnd_event) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign OVF = ovf_q;
`else
  assign OVF = 1'b0;
`endif

  assign CNT = cnt_q;
  assign TC  = tc_q;

  salida_triestado #(
    .WIDTH (WIDTH)
  ) u_salida (
    .oe_i   (OE),
    .data_i (cnt_q),
    .bus_o  (Q)
  );

endmodule

// File: doc/contador_ud_param.md
# contador_ud_param

Parametrised up/down counter with parallel load, programmable modulus, wrap or saturate mode, registered terminal-count pulse and a tri-state output bus. It is the next-generation drop-in for the fixed 4-bit load/enable/OE counter. It serves as the general counting element for timers, dividers and address sequencers driving shared buses.

## Interface
- `WIDTH`, default 8: counter width in bits, ≥ 2.
- `SAT`, default 0: boundary mode. 0 = wrap, 1 = saturate.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `EN` in 1: count enable.
- `LOAD` in 1: parallel load. Has priority over `EN`.
- `UP` in 1: direction. 1 = up, 0 = down.
- `OE` in 1: output enable for `Q`.
- `D` in WIDTH: load value.
- `MAX` in WIDTH: upper count limit. Range is 0..MAX.
- `Q` out WIDTH: tri-state count. Driven when `OE`=1, high-Z otherwise.
- `CNT` out WIDTH: always-driven count for internal consumers.
- `TC` out 1: registered one-cycle pulse on a boundary event.
- `OVF` out 1: sticky overflow flag. See Configuration.

## Operation
- Per edge, priority order:
  - `LOAD`: cnt ← D, loaded unchecked even if D > MAX. No TC. OVF cleared.
  - Else if `EN` and `UP`:
    - cnt ≥ MAX is a boundary event: wrap to 0 (SAT=0) or hold MAX (SAT=1).
    - Otherwise cnt+1.
  - Else if `EN` and !`UP`:
    - cnt == 0 is a boundary event: wrap to MAX (SAT=0) or hold 0 (SAT=1).
    - Otherwise cnt−1.
  - Else hold.
- Boundary detection uses the current `MAX`. A `MAX` change takes effect on the next edge. With cnt > MAX counting up, the next enabled edge is a boundary event.
- `MAX`=0: cnt stays 0. Every enabled edge is a boundary event in either direction.
- Arithmetic is WIDTH bits, unsigned. The compare against MAX occurs before any increment, so no carry ever reaches the register.
- `UP` may change on any cycle. Only its value at the edge matters.
- No state machine. The state is cnt, the TC register and the OVF register.

## Timing
- Reset values while `rst`=1 and after release:
  - `CNT`=0, `TC`=0, `OVF`=0.
  - `Q` = 0 if `OE`=1, else Z.
- `rst` asserted mid-count clears everything immediately, with no clock needed. The first update occurs on the first edge after deassertion.
- Latency: `CNT`/`Q` reflect a load or count one edge after the sampled controls.
- `TC`: high for exactly the cycle following the edge that performed a boundary event, aligned with the new `CNT` value.
  - Continuous boundary events give TC held high. This happens in SAT mode while still enabled at the limit, and with MAX=0.
- `LOAD` and `EN` together: the load wins and TC is 0.
- `OE` is combinational to `Q`, with no register stage.

## Configuration
- `CONT_OVF_FLAG_EN` defined:
  - `OVF` sets on the edge of any boundary event.
  - Stays set until `LOAD` or `rst`. A simultaneous LOAD clears it.
- `CONT_OVF_FLAG_EN` undefined:
  - The `OVF` port remains for instantiation compatibility and is tied to 0.
  - No flag register is built.

## Structure
- Package `contador_pkg`:
  - Constants `CONT_MODE_WRAP`=0 and `CONT_MODE_SAT`=1 for `SAT`.
  - Default width constant `CONT_WIDTH_DEF`=8.
- Sub-module `salida_triestado`: parametrised WIDTH-bit tri-state driver (`OE`, data in, bus out). It is reused by other bus-driving blocks.
- Next-state logic stays inline in `contador_ud_param`.

## Test plan
- Reset, then WIDTH=4, MAX=9, SAT=0, UP=1, EN=1 for 12 edges:
  - `CNT` goes 1..9, 0, 1, 2.
  - TC high only in the cycle where CNT=0.
- Same setup with UP=0 from 0:
  - `CNT` goes 9, 8, …
  - TC high in the cycle CNT first becomes 9.
  - OVF=1 with the macro defined, 0 without.
- SAT=1, MAX=9, load D=8, then 3 enabled up edges:
  - `CNT` goes 8, 9, 9, 9.
  - TC high for the last two cycles.
- LOAD=1 and EN=1 together with D=5 while CNT=9:
  - `CNT`=5, TC=0, OVF cleared.
  - With OE=0, `Q` is Z while `CNT`=5. Raising OE makes `Q`=5 in the same cycle.
- Assert `rst` between edges while CNT=7:
  - `CNT`, `TC` and `OVF` go to 0 without a clock edge.
  - After release, count resumes from 1.
